regfile_scoreboard: RTL and testbench

- Parametrised decode-stage register file with NRD read ports, one writeback port, same-cycle write-to-read bypass and a per-register busy scoreboard.
- The scoreboard gates instruction issue on RAW/WAW hazards.
- Sits in ID between the decoder (read addresses, destination) and the WB stage (write data).
- Also provides a saturating stall-cycle counter for performance monitoring.

---
 rtl/regfile_scoreboard.sv | 131 +++++++++++++
 tb/tb_regfile_scoreboard.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard
//
// Decode-stage register file with NRD combinational read ports, one writeback
// port, a same-cycle writeback-to-read bypass and a per-register busy
// scoreboard that holds back instructions with RAW/WAW hazards. A saturating
// counter records how many cycles a presented instruction was held back.
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous, active-low reset
//   rs_addr    NRD read addresses, port k at [k*AW +: AW]
//   rs_used    per-port "operand needed" flags (hazard check only)
//   rs_data    NRD read data words, port k at [k*XLEN +: XLEN]
//   iss_valid  decoder presents an instruction
//   iss_wr     instruction writes a destination register
//   iss_rd     destination register
//   iss_ready  instruction may issue this cycle (independent of iss_valid)
//   wb_en      writeback valid
//   wb_addr    writeback register
//   wb_data    writeback data
//   flush      clears every busy bit; blocks issue during the flush cycle
//   busy_vec   current scoreboard bits
//   stall_cnt  saturating count of cycles with iss_valid & ~iss_ready
module regfile_scoreboard #(
    parameter int XLEN  = 32,
    parameter int NREG  = 32,
    parameter int NRD   = 2,
    parameter int CNT_W = 16,
    localparam int AW   = $clog2(NREG)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NRD*AW-1:0]   rs_addr,
    input  logic [NRD-1:0]      rs_used,
    output logic [NRD*XLEN-1:0] rs_data,
    input  logic                iss_valid,
    input  logic                iss_wr,
    input  logic [AW-1:0]       iss_rd,
    output logic                iss_ready,
    input  logic                wb_en,
    input  logic [AW-1:0]       wb_addr,
    input  logic [XLEN-1:0]     wb_data,
    input  logic                flush,
    output logic [NREG-1:0]     busy_vec,
    output logic [CNT_W-1:0]    stall_cnt
);

    logic [XLEN-1:0]  regs_reg [NREG];
    logic [NREG-1:0]  busy_reg;
    logic [NREG-1:0]  busy_next;
    logic [CNT_W-1:0] stall_cnt_reg;
    logic [CNT_W-1:0] stall_cnt_next;

    logic             wb_clr;
    logic             iss_fire;
    logic             iss_set;
    logic [NREG-1:0]  clr_vec;
    logic [NREG-1:0]  set_vec;
    logic [NREG-1:0]  eff_busy;
    logic [NRD-1:0]   raw_hit;
    logic             waw_hit;

    // x0 is never written, so a writeback to it neither stores nor releases.
    assign wb_clr   = wb_en && (wb_addr != '0);
    assign iss_fire = iss_valid && iss_ready;
    assign iss_set  = iss_fire && iss_wr && (iss_rd != '0);

    // Per-register decode of the clear/set strobes and the effective busy
    // view, which lets a writeback landing this cycle release its consumer.
    generate
        for (genvar gi = 0; gi < NREG; gi++) begin : g_reg
            assign clr_vec[gi]  = wb_clr && (wb_addr == AW'(gi));
            assign set_vec[gi]  = iss_set && (iss_rd == AW'(gi));
            assign eff_busy[gi] = busy_reg[gi] && !clr_vec[gi];
            // A new producer outranks the retiring one; flush outranks both.
            assign busy_next[gi] = flush       ? 1'b0 :
                                   set_vec[gi] ? 1'b1 :
                                   clr_vec[gi] ? 1'b0 :
                                                 busy_reg[gi];
        end
    endgenerate

    // Read ports with x0 forcing and writeback bypass, plus the RAW check.
    generate
        for (genvar gi = 0; gi < NRD; gi++) begin : g_rd
            logic [AW-1:0] addr;
            assign addr = rs_addr[gi*AW +: AW];
            assign rs_data[gi*XLEN +: XLEN] =
                (addr == '0)                  ? '0      :
                (wb_en && (wb_addr == addr))  ? wb_data :
                                                regs_reg[addr];
            assign raw_hit[gi] = rs_used[gi] && (addr != '0) && eff_busy[addr];
        end
    endgenerate

    assign waw_hit   = iss_wr && (iss_rd != '0) && eff_busy[iss_rd];
    assign iss_ready = !(|raw_hit) && !waw_hit && !flush;

    always_comb begin
        stall_cnt_next = stall_cnt_reg;
        if (iss_valid && !iss_ready && (stall_cnt_reg != '1)) begin
            stall_cnt_next = stall_cnt_reg + CNT_W'(1);
        end
    end

    // Register contents: flush does not touch data, so a writeback coinciding
    // with a flush still lands.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs_reg[i] <= '0;
            end
        end else if (wb_clr) begin
            regs_reg[wb_addr] <= wb_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_reg      <= '0;
            stall_cnt_reg <= '0;
        end else begin
            busy_reg      <= busy_next;
            stall_cnt_reg <= stall_cnt_next;
        end
    end

    assign busy_vec  = busy_reg;
    assign stall_cnt = stall_cnt_reg;

endmodule

// File: tb/tb_regfile_scoreboard.sv
module tb_regfile_scoreboard;

    localparam int XLEN  = 32;
    localparam int NREG  = 32;
    localparam int NRD   = 2;
    localparam int CNT_W = 4;
    localparam int AW    = 5;

    localparam int K_RD0   = 0;
    localparam int K_RD1   = 1;
    localparam int K_READY = 2;
    localparam int K_BUSY  = 3;
    localparam int K_STALL = 4;

    logic                clk;
    logic                rst;
    logic [NRD*AW-1:0]   rs_addr;
    logic [NRD-1:0]      rs_used;
    logic [NRD*XLEN-1:0] rs_data;
    logic                iss_valid;
    logic                iss_wr;
    logic [AW-1:0]       iss_rd;
    logic                iss_ready;
    logic                wb_en;
    logic [AW-1:0]       wb_addr;
    logic [XLEN-1:0]     wb_data;
    logic                flush;
    logic [NREG-1:0]     busy_vec;
    logic [CNT_W-1:0]    stall_cnt;

    regfile_scoreboard #(
        .XLEN  (XLEN),
        .NREG  (NREG),
        .NRD   (NRD),
        .CNT_W (CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rs_addr   (rs_addr),
        .rs_used   (rs_used),
        .rs_data   (rs_data),
        .iss_valid (iss_valid),
        .iss_wr    (iss_wr),
        .iss_rd    (iss_rd),
        .iss_ready (iss_ready),
        .wb_en     (wb_en),
        .wb_addr   (wb_addr),
        .wb_data   (wb_data),
        .flush     (flush),
        .busy_vec  (busy_vec),
        .stall_cnt (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          kind;
        logic [31:0] exp;
    } sb_t;

    sb_t sb_q[$];
    int  checks = 0;
    int  errors = 0;

    // Reference state, updated once per clock edge from the driven inputs.
    logic [31:0] m_regs [32];
    logic [31:0] m_busy;
    int          m_stall;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end else begin
            $display("ok   %s: %h", tag, obs);
        end
    endtask

    task automatic push(input int kind, input logic [31:0] exp);
        sb_t e;
        e.kind = kind;
        e.exp  = exp;
        sb_q.push_back(e);
    endtask

    task automatic drain();
        sb_t         e;
        logic [31:0] obs;
        string       tag;
        #1;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            case (e.kind)
                K_RD0:   begin obs = rs_data[31:0];          tag = $sformatf("rd0[x%0d]", rs_addr[4:0]); end
                K_RD1:   begin obs = rs_data[63:32];         tag = $sformatf("rd1[x%0d]", rs_addr[9:5]); end
                K_READY: begin obs = {31'd0, iss_ready};     tag = "iss_ready"; end
                K_BUSY:  begin obs = busy_vec;               tag = "busy_vec"; end
                default: begin obs = {28'd0, stall_cnt};     tag = "stall_cnt"; end
            endcase
            check_val(tag, obs, e.exp);
        end
    endtask

    function automatic logic [31:0] model_rd(input logic [4:0] a);
        if (a == 5'd0) return 32'd0;
        if (wb_en && wb_addr == a) return wb_data;
        return m_regs[a];
    endfunction

    function automatic logic model_ready();
        logic [31:0] eb;
        logic [4:0]  a;
        eb = m_busy;
        if (wb_en && wb_addr != 5'd0) eb[wb_addr] = 1'b0;
        for (int k = 0; k < NRD; k++) begin
            a = rs_addr[k*AW +: AW];
            if (rs_used[k] && a != 5'd0 && eb[a]) return 1'b0;
        end
        if (iss_wr && iss_rd != 5'd0 && eb[iss_rd]) return 1'b0;
        if (flush) return 1'b0;
        return 1'b1;
    endfunction

    task automatic push_model();
        push(K_RD0, model_rd(rs_addr[4:0]));
        push(K_RD1, model_rd(rs_addr[9:5]));
        push(K_READY, {31'd0, model_ready()});
        push(K_BUSY, m_busy);
        push(K_STALL, m_stall);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
        m_busy  = 32'd0;
        m_stall = 0;
    endtask

    // Advance one clock: fold the current inputs into the model, then move
    // to just after the rising edge where new stimulus is applied.
    task automatic tick();
        logic rdy;
        rdy = model_ready();
        if (wb_en && wb_addr != 5'd0) m_regs[wb_addr] = wb_data;
        if (flush) begin
            m_busy = 32'd0;
        end else begin
            if (wb_en && wb_addr != 5'd0) m_busy[wb_addr] = 1'b0;
            if (iss_valid && rdy && iss_wr && iss_rd != 5'd0) m_busy[iss_rd] = 1'b1;
        end
        if (iss_valid && !rdy && m_stall < 15) m_stall++;
        @(posedge clk);
        #1;
    endtask

    task automatic set_rs(input logic [4:0] a0, input logic [4:0] a1, input logic u0, input logic u1);
        rs_addr = {a1, a0};
        rs_used = {u1, u0};
    endtask

    task automatic set_iss(input logic v, input logic w, input logic [4:0] rd);
        iss_valid = v;
        iss_wr    = w;
        iss_rd    = rd;
    endtask

    task automatic set_wb(input logic en, input logic [4:0] a, input logic [31:0] d);
        wb_en   = en;
        wb_addr = a;
        wb_data = d;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0;
        flush = 1'b0;
        set_rs(5'd0, 5'd0, 1'b0, 1'b0);
        set_iss(1'b1, 1'b0, 5'd0);
        set_wb(1'b0, 5'd0, 32'd0);
        model_reset();

        // Outputs during reset, before any clock edge.
        #2;
        push(K_BUSY, 32'd0);
        push(K_STALL, 32'd0);
        push(K_READY, 32'd1);
        push(K_RD0, 32'd0);
        drain();

        @(posedge clk);
        #1;
        rst = 1'b1;
        iss_valid = 1'b0;

        // Every register reads zero on both ports.
        for (int a = 0; a < 32; a += 2) begin
            set_rs(5'(a), 5'(a + 1), 1'b0, 1'b0);
            push(K_RD0, 32'd0);
            push(K_RD1, 32'd0);
            drain();
        end

        // Bypass, then stored value, then x0 write ignored.
        set_wb(1'b1, 5'd5, 32'hDEADBEEF);
        set_rs(5'd5, 5'd5, 1'b0, 1'b0);
        push(K_RD0, 32'hDEADBEEF);
        push(K_RD1, 32'hDEADBEEF);
        drain();
        tick();
        set_wb(1'b0, 5'd0, 32'd0);
        push(K_RD0, 32'hDEADBEEF);
        drain();
        set_wb(1'b1, 5'd0, 32'h1234);
        set_rs(5'd0, 5'd5, 1'b0, 1'b0);
        push(K_RD0, 32'd0);
        push(K_BUSY, 32'd0);
        drain();
        tick();
        set_wb(1'b0, 5'd0, 32'd0);
        push(K_RD0, 32'd0);
        drain();

        // RAW hazard on x7: three stalled cycles, then released by writeback.
        set_iss(1'b1, 1'b1, 5'd7);
        push(K_READY, 32'd1);
        drain();
        tick();
        set_iss(1'b1, 1'b0, 5'd0);
        set_rs(5'd7, 5'd0, 1'b1, 1'b0);
        push(K_BUSY, 32'h0000_0080);
        drain();
        for (int i = 0; i < 3; i++) begin
            push(K_READY, 32'd0);
            drain();
            tick();
        end
        push(K_STALL, 32'd3);
        set_wb(1'b1, 5'd7, 32'h55);
        push(K_READY, 32'd1);
        push(K_RD0, 32'h55);
        drain();
        tick();
        set_wb(1'b0, 5'd0, 32'd0);
        set_iss(1'b0, 1'b0, 5'd0);
        set_rs(5'd7, 5'd0, 1'b0, 1'b0);
        push(K_BUSY, 32'd0);
        push(K_RD0, 32'h55);
        push(K_STALL, 32'd3);
        drain();

        // WAW on x9, then same-cycle writeback + reissue keeps x9 busy.
        set_iss(1'b1, 1'b1, 5'd9);
        push(K_READY, 32'd1);
        drain();
        tick();
        push(K_BUSY, 32'h0000_0200);
        push(K_READY, 32'd0);
        drain();
        tick();
        set_wb(1'b1, 5'd9, 32'h99);
        push(K_READY, 32'd1);
        drain();
        tick();
        set_iss(1'b0, 1'b0, 5'd0);
        push(K_BUSY, 32'h0000_0200);
        push(K_STALL, 32'd4);
        drain();
        tick();
        set_wb(1'b0, 5'd0, 32'd0);
        push(K_BUSY, 32'd0);
        drain();

        // Flush with busy x3/x4 and a coincident writeback to x10.
        set_iss(1'b1, 1'b1, 5'd3);
        tick();
        set_iss(1'b1, 1'b1, 5'd4);
        tick();
        set_iss(1'b1, 1'b0, 5'd0);
        push(K_BUSY, 32'h0000_0018);
        drain();
        flush = 1'b1;
        set_wb(1'b1, 5'd10, 32'hA5A5_0F0F);
        push(K_READY, 32'd0);
        drain();
        tick();
        flush = 1'b0;
        set_iss(1'b0, 1'b0, 5'd0);
        set_wb(1'b0, 5'd0, 32'd0);
        set_rs(5'd5, 5'd7, 1'b0, 1'b0);
        push(K_BUSY, 32'd0);
        push(K_RD0, 32'hDEADBEEF);
        push(K_RD1, 32'h55);
        push(K_STALL, 32'd5);
        drain();
        set_rs(5'd10, 5'd9, 1'b0, 1'b0);
        push(K_RD0, 32'hA5A5_0F0F);
        push(K_RD1, 32'h99);
        drain();

        // Random writebacks/reads against the reference model.
        for (int i = 0; i < 30; i++) begin
            set_wb($urandom_range(0, 1) == 1, 5'($urandom_range(0, 31)), $urandom);
            set_rs(5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 1'b0, 1'b0);
            if (i % 4 == 0) rs_addr[4:0] = wb_addr;
            push_model();
            drain();
            tick();
        end
        set_wb(1'b0, 5'd0, 32'd0);

        // Long stall on x2 saturates the 4-bit counter.
        set_iss(1'b1, 1'b1, 5'd2);
        tick();
        set_iss(1'b1, 1'b0, 5'd0);
        set_rs(5'd2, 5'd0, 1'b1, 1'b0);
        for (int i = 0; i < 20; i++) begin
            push_model();
            drain();
            tick();
        end
        push(K_STALL, 32'd15);
        push(K_READY, 32'd0);
        drain();

        // Asynchronous reset mid-stall, away from any clock edge.
        #2;
        rst = 1'b0;
        model_reset();
        push(K_STALL, 32'd0);
        push(K_BUSY, 32'd0);
        push(K_RD1, 32'd0);
        drain();
        set_rs(5'd5, 5'd10, 1'b0, 1'b0);
        push(K_RD0, 32'd0);
        push(K_RD1, 32'd0);
        drain();
        #1;
        rst = 1'b1;
        set_iss(1'b0, 1'b0, 5'd0);
        tick();
        push_model();
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
